// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
//   div_state_t      : divider control states
//   REM_HI / QUO_LO  : slot index of each field inside the 2*WIDTH result word
//   DIV_WIDTH_DEFAULT: default operand width
//   div_params_legal : parameter legality check used at elaboration
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Result word is {remainder, quotient}; field k occupies [k*WIDTH +: WIDTH].
  localparam int REM_HI = 1;
  localparam int QUO_LO = 0;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic bit div_params_legal(input int width, input int bpc);
    return (width >= 8) && ((width % 2) == 0) &&
           ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
           ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   i_rem     : current partial remainder (always < divisor)
//   i_divisor : divisor magnitude
//   i_bit     : next dividend bit shifted into the remainder
//   o_rem     : updated partial remainder
//   o_qbit    : retired quotient bit (1 = subtraction kept)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_partial;
  logic           w_borrow;
  logic           w_unused_partial_msb;

  // One extra bit above the WIDTH+1-bit partial captures the borrow.
  assign {w_borrow, w_partial} = {1'b0, i_rem, i_bit} - {2'b00, i_divisor};

  assign o_qbit = ~w_borrow;
  // When the subtraction is kept the partial is below the divisor, so its
  // top bit is always zero and the low WIDTH bits are the full remainder.
  // On borrow {i_rem, i_bit} is below the divisor too, so dropping its MSB
  // is equally lossless.
  assign o_rem  = w_borrow ? {i_rem[WIDTH-2:0], i_bit} : w_partial[WIDTH-1:0];

  assign w_unused_partial_msb = w_partial[WIDTH];

endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative restoring integer divider with configurable width and
// quotient bits per cycle, early-out, divide-by-zero flag and operand latching.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_start         : level request, held for the whole operation
//   i_cancel        : abort; dominates i_start
//   i_signed_div    : 1 = two's-complement divide (sampled at issue)
//   i_dividend      : numerator   (sampled at issue)
//   i_divisor       : denominator (sampled at issue)
//   o_busy          : high in every state except IDLE
//   o_ready         : result valid
//   o_div_by_zero   : divisor was zero (valid with o_ready)
//   o_result        : {remainder, quotient}
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH_DEFAULT,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_cancel,
  input  logic               i_signed_div,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_ready,
  output logic               o_div_by_zero,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if (!div_params_legal(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
    $error("mdu_div: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  div_state_t         r_state;
  div_state_t         w_state_next;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;       // holds the dividend, shifted out as quotient bits shift in
  logic [WIDTH-1:0]   r_dsr;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic               r_dvd_sign;
  logic               r_quo_sign;
  logic               r_dbz_pend;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_result;

  // ---------------- issue-time operand conditioning ----------------
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_dsr_zero;
  logic             w_early;
  logic             w_issue;

  assign w_dvd_neg  = i_signed_div & i_dividend[WIDTH-1];
  assign w_dsr_neg  = i_signed_div & i_divisor[WIDTH-1];
  // The magnitude of MIN is 2^(WIDTH-1), which is exact as an unsigned value.
  assign w_dvd_mag  = w_dvd_neg ? (-i_dividend) : i_dividend;
  assign w_dsr_mag  = w_dsr_neg ? (-i_divisor)  : i_divisor;
  assign w_dsr_zero = (i_divisor == '0);
  assign w_early    = (w_dvd_mag < w_dsr_mag);
  assign w_issue    = (r_state == IDLE) && i_start && !i_cancel;

  // ---------------- chained restoring steps ----------------
  logic [WIDTH-1:0]          w_rem_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0]          w_quo_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_qbit;

  assign w_rem_chain[0] = r_rem;
  assign w_quo_chain[0] = r_quo;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (w_rem_chain[gi]),
      .i_divisor (r_dsr),
      .i_bit     (w_quo_chain[gi][WIDTH-1]),
      .o_rem     (w_rem_chain[gi+1]),
      .o_qbit    (w_qbit[gi])
    );
    assign w_quo_chain[gi+1] = {w_quo_chain[gi][WIDTH-2:0], w_qbit[gi]};
  end

  // ---------------- sign fix-up ----------------
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // MIN / -1 falls out naturally: the magnitude quotient is 2^(WIDTH-1)
  // and the quotient sign is positive, so MIN is returned unchanged.
  assign w_quo_fix = (r_signed && r_quo_sign) ? (-r_quo) : r_quo;
  assign w_rem_fix = (r_signed && r_dvd_sign) ? (-r_rem) : r_rem;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start && !i_cancel) begin
          w_state_next = (w_dsr_zero || w_early) ? FIX : BUSY;
        end
      end
      BUSY: begin
        if (i_cancel) begin
          w_state_next = IDLE;
        end else if (r_cnt == CW'(N - 1)) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = i_cancel ? IDLE : DONE;
      end
      DONE: begin
        if (i_cancel || !i_start) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy        = (r_state != IDLE);
    o_ready       = (r_state == DONE);
    o_div_by_zero = r_dbz;
    o_result      = r_result;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr      <= '0;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_dvd_sign <= 1'b0;
      r_quo_sign <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_dbz      <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_dsr      <= w_dsr_mag;
            r_signed   <= i_signed_div;
            r_dvd_sign <= w_dvd_neg;
            r_quo_sign <= w_dvd_neg ^ w_dsr_neg;
            r_cnt      <= '0;
            r_dbz_pend <= w_dsr_zero;
            if (w_dsr_zero) begin
              r_rem <= '0;
              r_quo <= '0;
            end else if (w_early) begin
              r_rem <= w_dvd_mag;
              r_quo <= '0;
            end else begin
              r_rem <= '0;
              r_quo <= w_dvd_mag;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_chain[BITS_PER_CYCLE];
          r_quo <= w_quo_chain[BITS_PER_CYCLE];
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          if (!i_cancel) begin
            r_result[REM_HI*WIDTH +: WIDTH] <= w_rem_fix;
            r_result[QUO_LO*WIDTH +: WIDTH] <= w_quo_fix;
            r_dbz                           <= r_dbz_pend;
          end
        end
        DONE: begin
          if (i_cancel || !i_start) begin
            r_result <= '0;
            r_dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
